// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM bundle seen by the on-chip RAM arbiter: two requester ports plus the RAM s1 side.
// The slave modport is the arbiter's view; master is the view of the requesters and RAM around it.
interface onchip_mem_arbiter_if;
    logic [9:0]  p0_address;
    logic [3:0]  p0_byteenable;
    logic        p0_read;
    logic        p0_write;
    logic [31:0] p0_writedata;
    logic        p0_waitrequest;
    logic [31:0] p0_readdata;
    logic        p0_readdatavalid;

    logic [9:0]  p1_address;
    logic [3:0]  p1_byteenable;
    logic        p1_read;
    logic        p1_write;
    logic [31:0] p1_writedata;
    logic        p1_waitrequest;
    logic [31:0] p1_readdata;
    logic        p1_readdatavalid;

    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    modport slave (
        input  p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
        output p0_waitrequest, p0_readdata, p0_readdatavalid,
        input  p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
        output p1_waitrequest, p1_readdata, p1_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
        input  ram_readdata
    );

    modport master (
        output p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
        input  p0_waitrequest, p0_readdata, p0_readdatavalid,
        output p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
        input  p1_waitrequest, p1_readdata, p1_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
        output ram_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port 1024x32 RAM between two Avalon-MM requesters, one access per cycle.
// Read latency 1 cycle; the losing requester is held off with combinational waitrequest.
module onchip_mem_arbiter #(
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_mem_arbiter_if.slave  bus
);

    typedef struct packed {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
    } mreq_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    mreq_t       port_req [2];
    mreq_t       gnt_req;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        any_grant;

    logic        last_grant, last_grant_nxt;
    logic [7:0]  starve_cnt, starve_cnt_nxt;
    logic        rd_pending, rd_pending_nxt;
    logic        rd_port, rd_port_nxt;

    assign port_req[0] = {bus.p0_address, bus.p0_byteenable, bus.p0_read, bus.p0_write, bus.p0_writedata};
    assign port_req[1] = {bus.p1_address, bus.p1_byteenable, bus.p1_read, bus.p1_write, bus.p1_writedata};

    assign req[0]    = port_req[0].rd | port_req[0].wr;
    assign req[1]    = port_req[1].rd | port_req[1].wr;
    assign any_grant = |grant;
    assign gnt_req   = port_req[grant[1]];

    // Contention only matters when both ask; a lone requester always wins.
    always_comb begin : arbitrate
        grant = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                if (MODE == 0) begin
                    grant = last_grant ? 2'b01 : 2'b10;
                end else begin
                    grant = (starve_cnt == LIMIT) ? 2'b10 : 2'b01;
                end
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            last_grant <= 1'b1;
            starve_cnt <= '0;
            rd_pending <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            last_grant <= last_grant_nxt;
            starve_cnt <= starve_cnt_nxt;
            rd_pending <= rd_pending_nxt;
            rd_port    <= rd_port_nxt;
        end
    end

    always_comb begin : next_state
        last_grant_nxt = last_grant;
        starve_cnt_nxt = starve_cnt;
        rd_pending_nxt = 1'b0;
        rd_port_nxt    = rd_port;

        if (any_grant) begin
            last_grant_nxt = grant[1];
        end

        if (!req[1] || grant[1]) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt_nxt = starve_cnt + 8'd1;
        end

        // A write sharing the cycle with an outstanding return never touches rd_pending's owner.
        if (any_grant && !gnt_req.wr) begin
            rd_pending_nxt = 1'b1;
            rd_port_nxt    = grant[1];
        end
    end

    always_comb begin : outputs
        bus.ram_chipselect = 1'b0;
        bus.ram_write      = 1'b0;
        bus.ram_address    = '0;
        bus.ram_byteenable = '0;
        bus.ram_writedata  = '0;
        if (any_grant) begin
            bus.ram_chipselect = 1'b1;
            bus.ram_write      = gnt_req.wr;
            bus.ram_address    = gnt_req.addr;
            bus.ram_byteenable = gnt_req.wr ? gnt_req.be : 4'hF;
            bus.ram_writedata  = gnt_req.wdata;
        end

        bus.p0_waitrequest   = req[0] & ~grant[0];
        bus.p1_waitrequest   = req[1] & ~grant[1];
        bus.p0_readdatavalid = rd_pending & ~reset & ~rd_port;
        bus.p1_readdatavalid = rd_pending & ~reset & rd_port;
        bus.p0_readdata      = bus.ram_readdata;
        bus.p1_readdata      = bus.ram_readdata;
    end

endmodule
